// File: rtl/pu_div_ctrl.sv
// pu_div_ctrl: arbitrates two requesters onto one shared pu_div divider,
// sequences its write/wait/read strobes and returns the results on a
// valid/ready response channel tagged with the requester id.
module pu_div_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ATTR_WIDTH  = 4,
    parameter int INVALID     = 0,
    parameter int DIV_LATENCY = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    output logic                  req0_ready,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [DATA_WIDTH-1:0] resp_quotient,
    output logic [DATA_WIDTH-1:0] resp_remainder,
    output logic                  resp_invalid,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] div_data_in,
    output logic [ATTR_WIDTH-1:0] div_attr_in,
    output logic                  div_signal_wr,
    output logic                  div_signal_sel,
    output logic                  div_signal_oe,
    output logic                  div_res_select,
    input  logic [DATA_WIDTH-1:0] div_data_out,
    input  logic [ATTR_WIDTH-1:0] div_attr_out
);

    // Wait counter must hold DIV_LATENCY; never narrower than one bit.
    localparam int CNT_W = (DIV_LATENCY < 1) ? 1 : $clog2(DIV_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR_A = 3'd1,
        S_WR_B = 3'd2,
        S_WAIT = 3'd3,
        S_RD_Q = 3'd4,
        S_RD_R = 3'd5,
        S_RESP = 3'd6
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  last_grant_r;
    logic                  grant_s;
    logic                  take_s;
    logic [DATA_WIDTH-1:0] op_a_s;
    logic [DATA_WIDTH-1:0] b_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  wr_nxt_s;
    logic                  sel_nxt_s;
    logic                  oe_nxt_s;
    logic                  rs_nxt_s;
    logic [DATA_WIDTH-1:0] data_nxt_s;
    logic                  attr_unused_s;

    // Only the INVALID bit of the attribute bus is meaningful here.
    assign attr_unused_s = ^div_attr_out;

    // The controller never drives divider attributes.
    assign div_attr_in = {ATTR_WIDTH{1'b0}};

    // Round-robin choice: on a tie, the requester not served last wins.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Handshake only in IDLE and never while reset is asserted.
    assign take_s     = rst && (state_r == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = take_s && !grant_s;
    assign req1_ready = take_s && grant_s;
    assign op_a_s     = grant_s ? req1_a : req0_a;

    // Next-state sequencing through write, wait, read and response.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (take_s) begin
                    state_nxt_s = S_WR_A;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WR_A: state_nxt_s = S_WR_B;
            S_WR_B: begin
                if (DIV_LATENCY == 0) begin
                    state_nxt_s = S_RD_Q;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_WAIT: begin
                // <= 1 so a corrupted zero count cannot stall the FSM.
                if (cnt_r <= CNT_W'(1)) begin
                    state_nxt_s = S_RD_Q;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_RD_Q: state_nxt_s = S_RD_R;
            S_RD_R: state_nxt_s = S_RESP;
            S_RESP: begin
                // resp_valid is high throughout RESP, so resp_ready alone completes it.
                if (resp_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Divider strobes and write data for the upcoming state, so they can be registered.
    always_comb begin
        wr_nxt_s   = 1'b0;
        sel_nxt_s  = 1'b0;
        oe_nxt_s   = 1'b0;
        rs_nxt_s   = 1'b0;
        data_nxt_s = {DATA_WIDTH{1'b0}};
        case (state_nxt_s)
            S_WR_A: begin
                wr_nxt_s   = 1'b1;
                data_nxt_s = op_a_s;
            end
            S_WR_B: begin
                wr_nxt_s   = 1'b1;
                sel_nxt_s  = 1'b1;
                data_nxt_s = b_r;
            end
            S_RD_Q: begin
                oe_nxt_s = 1'b1;
            end
            S_RD_R: begin
                oe_nxt_s = 1'b1;
                rs_nxt_s = 1'b1;
            end
            default: begin
                wr_nxt_s = 1'b0;
            end
        endcase
    end

    // State register, arbitration pointer, divisor latch and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            last_grant_r <= 1'b1;
            b_r          <= {DATA_WIDTH{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (take_s) begin
                last_grant_r <= grant_s;
                b_r          <= grant_s ? req1_b : req0_b;
            end
            if (state_r == S_WR_B) begin
                cnt_r <= CNT_W'(DIV_LATENCY);
            end else if (state_r == S_WAIT) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end
    end

    // Registered divider controls and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_signal_wr  <= 1'b0;
            div_signal_sel <= 1'b0;
            div_signal_oe  <= 1'b0;
            div_res_select <= 1'b0;
            div_data_in    <= {DATA_WIDTH{1'b0}};
            resp_valid     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            div_signal_wr  <= wr_nxt_s;
            div_signal_sel <= sel_nxt_s;
            div_signal_oe  <= oe_nxt_s;
            div_res_select <= rs_nxt_s;
            div_data_in    <= data_nxt_s;
            resp_valid     <= (state_nxt_s == S_RESP);
            busy           <= (state_nxt_s != S_IDLE);
        end
    end

    // Response fields: id at handshake, results captured during the read cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_id        <= 1'b0;
            resp_quotient  <= {DATA_WIDTH{1'b0}};
            resp_remainder <= {DATA_WIDTH{1'b0}};
            resp_invalid   <= 1'b0;
        end else begin
            if (take_s) begin
                resp_id <= grant_s;
            end
            if (state_r == S_RD_Q) begin
                resp_quotient <= div_data_out;
                resp_invalid  <= div_attr_out[INVALID];
            end else if (state_r == S_RD_R) begin
                resp_remainder <= div_data_out;
                resp_invalid   <= resp_invalid | div_attr_out[INVALID];
            end
        end
    end

endmodule
